// File: rtl/ahb_pkg.sv
// Shared AHB types and helpers for the master-side multiplexer and its burst tracker.
package ahb_pkg;

    localparam int MASTER_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    // Zero means the burst has no fixed length (SINGLE or INCR).
    function automatic logic [4:0] burst_beats(input hburst_t b);
        case (b)
            WRAP4, INCR4:   return 5'd4;
            WRAP8, INCR8:   return 5'd8;
            WRAP16, INCR16: return 5'd16;
            default:        return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Counts accepted burst beats and pulses burst_abort when a fixed-length burst
// is cut short by a handover, a fresh NONSEQ or an IDLE.
module ahb_burst_tracker
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hready,
    input  logic       master_change,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    output logic [4:0] beat_cnt,
    output logic       burst_abort
);

    logic [4:0] burst_len;
    htrans_t    tr;
    logic       mid_burst;
    logic       abort_now;

    // Detection looks only at pre-edge state; the new transfer loads in the same edge.
    always_comb begin
        tr        = htrans_t'(htrans);
        mid_burst = (burst_len != 5'd0) && (beat_cnt != 5'd0) && (beat_cnt < burst_len);
        abort_now = mid_burst && (master_change || tr == NONSEQ || tr == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt    <= '0;
            burst_len   <= '0;
            burst_abort <= 1'b0;
        end else begin
            burst_abort <= 1'b0;
            if (hready) begin
                burst_abort <= abort_now;
                case (tr)
                    NONSEQ: begin
                        beat_cnt  <= 5'd1;
                        burst_len <= burst_beats(hburst_t'(hburst));
                    end
                    SEQ: begin
                        if (beat_cnt < 5'd16) beat_cnt <= beat_cnt + 5'd1;
                    end
                    IDLE:    beat_cnt <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ahb_master_mux.sv
// Shared AHB address/control/write-data mux driven by the arbiter's HMASTER,
// with the registered data-phase owner and burst beat tracking.
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int NMASTERS = 16,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [MASTER_W-1:0]    HMASTER,
    input  logic                   HMASTLOCK,
    input  logic                   HREADY,
    input  logic [NMASTERS*AW-1:0] HADDRx,
    input  logic [NMASTERS*2-1:0]  HTRANSx,
    input  logic [NMASTERS-1:0]    HWRITEx,
    input  logic [NMASTERS*3-1:0]  HSIZEx,
    input  logic [NMASTERS*3-1:0]  HBURSTx,
    input  logic [NMASTERS*DW-1:0] HWDATAx,
    output logic [AW-1:0]          HADDR,
    output logic [1:0]             HTRANS,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic                   HMASTLOCK_S,
    output logic [DW-1:0]          HWDATA,
    output logic [MASTER_W-1:0]    HMASTER_D,
    output logic                   DPHASE_VALID,
    output logic [4:0]             BEAT_CNT,
    output logic                   BURST_ABORT
);

    logic [1:0] trans_sel;
    logic       master_change;

    // An HMASTER value with no matching slot leaves every field at its idle default.
    always_comb begin
        HADDR     = '0;
        trans_sel = IDLE;
        HWRITE    = 1'b0;
        HSIZE     = '0;
        HBURST    = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (HMASTER == i[MASTER_W-1:0]) begin
                HADDR     = HADDRx[i*AW +: AW];
                trans_sel = HTRANSx[i*2 +: 2];
                HWRITE    = HWRITEx[i];
                HSIZE     = HSIZEx[i*3 +: 3];
                HBURST    = HBURSTx[i*3 +: 3];
            end
        end
        HTRANS      = HRESET ? IDLE : trans_sel;
        HMASTLOCK_S = HMASTLOCK && !HRESET;
    end

    // HREADY high completes the current data phase and accepts the pending address
    // phase; HREADY low is a wait state, so the data-phase owner holds.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HMASTER_D    <= '0;
            DPHASE_VALID <= 1'b0;
        end else if (HREADY) begin
            HMASTER_D    <= HMASTER;
            DPHASE_VALID <= (HTRANS == NONSEQ) || (HTRANS == SEQ);
        end
    end

    always_comb begin
        HWDATA = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (DPHASE_VALID && HMASTER_D == i[MASTER_W-1:0]) HWDATA = HWDATAx[i*DW +: DW];
        end
    end

    assign master_change = (HMASTER != HMASTER_D);

    ahb_burst_tracker u_burst_tracker (
        .clk           (HCLK),
        .rst           (HRESET),
        .hready        (HREADY),
        .master_change (master_change),
        .htrans        (HTRANS),
        .hburst        (HBURST),
        .beat_cnt      (BEAT_CNT),
        .burst_abort   (BURST_ABORT)
    );

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed bench for ahb_master_mux: a transaction-level model is checked every
// cycle, and hand-computed literals pin the key scenarios.
module tb_ahb_master_mux;

    localparam int NM = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [3:0]       HMASTER;
    logic             HMASTLOCK;
    logic             HREADY;
    logic [NM*AW-1:0] HADDRx;
    logic [NM*2-1:0]  HTRANSx;
    logic [NM-1:0]    HWRITEx;
    logic [NM*3-1:0]  HSIZEx;
    logic [NM*3-1:0]  HBURSTx;
    logic [NM*DW-1:0] HWDATAx;
    logic [AW-1:0]    HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic             HMASTLOCK_S;
    logic [DW-1:0]    HWDATA;
    logic [3:0]       HMASTER_D;
    logic             DPHASE_VALID;
    logic [4:0]       BEAT_CNT;
    logic             BURST_ABORT;

    ahb_master_mux #(.NMASTERS(NM), .AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HADDRx(HADDRx), .HTRANSx(HTRANSx), .HWRITEx(HWRITEx),
        .HSIZEx(HSIZEx), .HBURSTx(HBURSTx), .HWDATAx(HWDATAx), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HMASTLOCK_S(HMASTLOCK_S), .HWDATA(HWDATA), .HMASTER_D(HMASTER_D),
        .DPHASE_VALID(DPHASE_VALID), .BEAT_CNT(BEAT_CNT), .BURST_ABORT(BURST_ABORT)
    );

    // Clock / reset
    always #5 HCLK = ~HCLK;

    // Per-master stimulus slots, packed onto the flat buses
    logic [31:0] addr_a[NM];
    logic [1:0]  trans_a[NM];
    logic        write_a[NM];
    logic [2:0]  size_a[NM];
    logic [2:0]  burst_a[NM];
    logic [31:0] wdata_a[NM];

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            HADDRx[i*AW +: AW] = addr_a[i];
            HTRANSx[i*2 +: 2]  = trans_a[i];
            HWRITEx[i]         = write_a[i];
            HSIZEx[i*3 +: 3]   = size_a[i];
            HBURSTx[i*3 +: 3]  = burst_a[i];
            HWDATAx[i*DW +: DW] = wdata_a[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one record of the data-phase owner and the open burst
    int len_tab[8] = '{0, 0, 4, 4, 8, 8, 16, 16};
    int m_md, m_cnt, m_len;
    bit m_dv, m_abort;
    bit running = 1'b0;

    function automatic int cur_master();
        return int'(HMASTER);
    endfunction

    function automatic logic [1:0] exp_trans();
        int mi = cur_master();
        if (HRESET) return 2'b00;
        return (mi < NM) ? trans_a[mi] : 2'b00;
    endfunction

    always @(posedge HCLK) begin
        int mi;
        int et;
        bit open_burst;
        mi = cur_master();
        if (HRESET) begin
            m_md = 0; m_dv = 0; m_cnt = 0; m_len = 0; m_abort = 0;
            running = 1'b1;
        end else if (HREADY) begin
            et = int'(exp_trans());
            open_burst = (m_len > 0) && (m_cnt > 0) && (m_cnt < m_len);
            m_abort = open_burst && (mi != m_md || et == 2 || et == 0);
            if (et == 2) begin
                m_cnt = 1;
                m_len = len_tab[burst_a[mi]];
            end else if (et == 3) begin
                m_cnt = (m_cnt >= 16) ? 16 : m_cnt + 1;
            end else if (et == 0) begin
                m_cnt = 0;
            end
            m_md = mi;
            m_dv = (et >= 2);
        end else begin
            m_abort = 0;
        end
    end

    // Scoreboard: every output compared against the model each cycle
    always @(negedge HCLK) begin
        int mi;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic e_write;
        logic [2:0] e_size, e_burst;
        if (running) begin
            mi = cur_master();
            e_addr = (mi < NM) ? addr_a[mi] : 32'd0;
            e_write = (mi < NM) ? write_a[mi] : 1'b0;
            e_size = (mi < NM) ? size_a[mi] : 3'd0;
            e_burst = (mi < NM) ? burst_a[mi] : 3'd0;
            e_wdata = (m_dv && m_md < NM) ? wdata_a[m_md] : 32'd0;
            chk("haddr", 64'(HADDR), 64'(e_addr));
            chk("htrans", 64'(HTRANS), 64'(exp_trans()));
            chk("hwrite", 64'(HWRITE), 64'(e_write));
            chk("hsize", 64'(HSIZE), 64'(e_size));
            chk("hburst", 64'(HBURST), 64'(e_burst));
            chk("hmastlock_s", 64'(HMASTLOCK_S), 64'(HMASTLOCK && !HRESET));
            chk("hmaster_d", 64'(HMASTER_D), 64'(m_md));
            chk("dphase_valid", 64'(DPHASE_VALID), 64'(m_dv));
            chk("beat_cnt", 64'(BEAT_CNT), 64'(m_cnt));
            chk("burst_abort", 64'(BURST_ABORT), 64'(m_abort));
            chk("hwdata", 64'(HWDATA), 64'(e_wdata));
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_slot(input int m, input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] a);
        trans_a[m] = tr;
        burst_a[m] = bu;
        addr_a[m]  = a;
    endtask

    initial begin
        HRESET = 1'b1; HMASTER = 4'd2; HMASTLOCK = 1'b0; HREADY = 1'b1;
        for (int i = 0; i < NM; i++) begin
            addr_a[i] = 32'h100 * i; trans_a[i] = 2'b00; write_a[i] = i[0];
            size_a[i] = i[2:0]; burst_a[i] = 3'd0; wdata_a[i] = 32'hA5A5_0000 + i;
        end
        set_slot(2, 2'b10, 3'd3, 32'h0000_0200);

        // Reset held three cycles while master 2 requests NONSEQ
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_htrans", 64'(HTRANS), 64'd0);
            chk("rst_hmaster_d", 64'(HMASTER_D), 64'd0);
            chk("rst_beat_cnt", 64'(BEAT_CNT), 64'd0);
        end
        HRESET = 1'b0;
        step();
        chk("post_rst_hmaster_d", 64'(HMASTER_D), 64'd2);
        chk("post_rst_beat_cnt", 64'(BEAT_CNT), 64'd1);
        set_slot(2, 2'b00, 3'd3, 32'h0000_0200);
        step();
        chk("same_master_idle_abort", 64'(BURST_ABORT), 64'd1);

        // Single write from master 5
        HMASTER = 4'd5;
        set_slot(5, 2'b10, 3'd0, 32'h1000_0040);
        #1;
        chk("m5_haddr", 64'(HADDR), 64'h1000_0040);
        step();
        chk("m5_hmaster_d", 64'(HMASTER_D), 64'd5);
        chk("m5_hwdata", 64'(HWDATA), 64'hA5A5_0005);
        set_slot(5, 2'b00, 3'd0, 32'h1000_0040);
        step();

        // Master 3 INCR4 with two wait states on beat 2
        HMASTER = 4'd3;
        set_slot(3, 2'b10, 3'd3, 32'h300); step();
        set_slot(3, 2'b11, 3'd3, 32'h304); step();
        set_slot(3, 2'b11, 3'd3, 32'h308); HREADY = 1'b0;
        step(); step();
        chk("wait_beat_cnt", 64'(BEAT_CNT), 64'd2);
        chk("wait_hmaster_d", 64'(HMASTER_D), 64'd3);
        HREADY = 1'b1; step();
        set_slot(3, 2'b11, 3'd3, 32'h30C); step();
        chk("incr4_beat_cnt", 64'(BEAT_CNT), 64'd4);
        set_slot(3, 2'b00, 3'd3, 32'h30C); step();
        chk("incr4_no_abort", 64'(BURST_ABORT), 64'd0);

        // Master 1 INCR8 cut after three beats by master 7 WRAP16
        HMASTER = 4'd1;
        set_slot(1, 2'b10, 3'd5, 32'h100); step();
        set_slot(1, 2'b11, 3'd5, 32'h104); step(); step();
        HMASTER = 4'd7;
        set_slot(7, 2'b10, 3'd6, 32'h700); step();
        chk("handover_abort", 64'(BURST_ABORT), 64'd1);
        chk("handover_beat_cnt", 64'(BEAT_CNT), 64'd1);
        set_slot(7, 2'b11, 3'd6, 32'h704); step();
        chk("abort_one_cycle", 64'(BURST_ABORT), 64'd0);
        repeat (13) step();
        chk("wrap16_beat_cnt", 64'(BEAT_CNT), 64'd15);

        // Master 4 INCR: aborts the 16-beat burst at 15, then runs 20 beats
        HMASTER = 4'd4;
        set_slot(4, 2'b10, 3'd1, 32'h400); step();
        chk("wrap16_len_abort", 64'(BURST_ABORT), 64'd1);
        set_slot(4, 2'b11, 3'd1, 32'h404);
        repeat (19) step();
        chk("incr_saturate", 64'(BEAT_CNT), 64'd16);
        HMASTER = 4'd6;
        set_slot(6, 2'b10, 3'd0, 32'h600); step();
        chk("incr_handover_no_abort", 64'(BURST_ABORT), 64'd0);
        set_slot(6, 2'b00, 3'd0, 32'h600); step();

        // Out-of-range master
        HMASTER = 4'd15;
        #1;
        chk("oor_htrans", 64'(HTRANS), 64'd0);
        chk("oor_haddr", 64'(HADDR), 64'd0);
        step();
        chk("oor_dphase_valid", 64'(DPHASE_VALID), 64'd0);
        chk("oor_hwdata", 64'(HWDATA), 64'd0);

        // Locked burst interrupted by reset
        HMASTER = 4'd3; HMASTLOCK = 1'b1;
        set_slot(3, 2'b10, 3'd3, 32'h300);
        #1;
        chk("lock_forward", 64'(HMASTLOCK_S), 64'd1);
        step();
        set_slot(3, 2'b11, 3'd3, 32'h304); step();
        HRESET = 1'b1;
        #1;
        chk("rst_lock_low", 64'(HMASTLOCK_S), 64'd0);
        step();
        chk("rst_mid_no_abort", 64'(BURST_ABORT), 64'd0);
        chk("rst_mid_beat_cnt", 64'(BEAT_CNT), 64'd0);
        chk("rst_mid_hmaster_d", 64'(HMASTER_D), 64'd0);
        HRESET = 1'b0; HMASTLOCK = 1'b0;
        set_slot(3, 2'b00, 3'd3, 32'h304);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
